instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 127 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// master = fetch side, slave = memory side.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage with redirect and stall.
// Optional IFETCH_MISALIGN_EN: misaligned redirect halts with sticky error.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PCSrc,
  input  logic [31:0]   PCTarget,
  input  logic          Stall,
  instr_fetch_if.master imem,
  output logic [31:0]   Instr,
  output logic [31:0]   PC,
  output logic [31:0]   PCPlus4,
  output logic          InstrValid,
  output logic          MisalignErr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    HALT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fetch_pc_q;
  logic [31:0] fetch_pc_d;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        load;
  logic        consume;
  logic        misalign;
  logic [31:0] target;

  assign target = PCTarget & 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_EN
  logic err_q;
  logic set_err;

  assign misalign    = PCSrc & (|PCTarget[1:0]);
  assign set_err     = consume & misalign;
  assign MisalignErr = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end
`else
  assign misalign    = 1'b0;
  assign MisalignErr = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    load       = 1'b0;
    consume    = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          load    = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!Stall) begin
          consume = 1'b1;
          // a bad redirect parks here with fetch_pc untouched
          if (misalign) begin
            state_d = HALT;
          end else begin
            fetch_pc_d = PCSrc ? target : pc4_q;
            state_d    = REQ;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP;
      pc_q       <= RESET_PC;
      pc4_q      <= RESET_PC + 32'd4;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (load) begin
        instr_q <= imem.imem_rdata;
        pc_q    <= fetch_pc_q;
        pc4_q   <= fetch_pc_q + 32'd4;
        valid_q <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = fetch_pc_q;

  assign Instr      = instr_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc4_q;
  assign InstrValid = valid_q;

endmodule
